uart_digit_rx: RTL and testbench
================================

# uart_digit_rx

UART receiver for the board's `uart_rx_pin`, which the seven-segment digit display currently leaves unused. It deserialises 8N1 frames (optionally 8E1) at a fixed baud rate and presents each received byte. ASCII digits '0'–'9' are decoded into a held 4-bit digit value that can drive the display's digit-to-segment logic in place of the free-running counter.

## Interface
- `CLK_HZ`, 12000000, input clock frequency in Hz.
- `BAUD`, 9600, line rate; `CLKS_PER_BIT = CLK_HZ/BAUD` (1250 at defaults), integer division.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  reset; **one clock; reset is asynchronous and active-low**.
- `uart_rx_pin`  input  1  asynchronous serial line, idle high, LSB first.
- `rx_byte`  output  8  last accepted byte; reset 8'h00.
- `rx_byte_valid`  output  1  one-cycle pulse when `rx_byte` updates; reset 0.
- `digit`  output  4  last accepted ASCII digit value 0–9; reset 4'd1.
- `digit_valid`  output  1  one-cycle pulse when `digit` updates; reset 0.
- `frame_err`  output  1  one-cycle pulse on bad stop bit; reset 0.
- `parity_err`  output  1  one-cycle pulse on parity mismatch; reset 0; constant 0 when parity is compiled out.

## Operation
- Input path: 2-flop synchroniser on `uart_rx_pin`; sync flops reset to 1 (idle). All logic uses the synchronised value `rx_s`.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP, BREAK.
- IDLE: on `rx_s == 0`, clear the baud counter and go to START.
- START: after `CLKS_PER_BIT/2` cycles, sample `rx_s`.
  - Sample 0 → DATA, bit index 0.
  - Sample 1 → IDLE (false start). No outputs change.
- DATA: every `CLKS_PER_BIT` cycles, sample one bit into the shift register, LSB first. After bit 7 → PARITY if enabled, otherwise STOP.
- PARITY: one bit period later, sample the parity bit. Store the mismatch flag, then → STOP.
- STOP: one bit period later, sample the stop bit.
  - Stop = 1, no parity mismatch: load `rx_byte` and pulse `rx_byte_valid`. If the byte is in 8'h30–8'h39, also load `digit = byte − 8'h30` and pulse `digit_valid` in the same cycle. Other bytes leave `digit` unchanged. → IDLE.
  - Stop = 1, parity mismatch: pulse `parity_err` only; byte discarded. → IDLE.
  - Stop = 0: pulse `frame_err` only; byte discarded, regardless of parity. → BREAK.
- BREAK: wait until `rx_s == 1`, then → IDLE. Prevents a held-low line from retriggering start detection.
- Baud counter width: `$clog2(CLKS_PER_BIT)` bits; it wraps to 0 at each sample point.
- Reset mid-frame: all state returns to IDLE immediately and outputs take their reset values. A partial frame is never reported.

## Timing
- Pin to `rx_s`: 2 cycles.
- START sample: `CLKS_PER_BIT/2` cycles after the IDLE exit. Each subsequent sample is exactly `CLKS_PER_BIT` cycles later.
- All outputs are registered. Pulses assert in the cycle after the stop-bit sample and last exactly 1 cycle.
- Accepted start edge to `rx_byte_valid`: (1 + 8 [+1] ) × `CLKS_PER_BIT` + `CLKS_PER_BIT/2` + 1 cycles from the IDLE exit.
- A back-to-back frame is accepted: its start bit is detected from IDLE on the cycle after the STOP sample. Receiving the next frame's start edge within the remaining half stop bit is fine.
- There is no backpressure. `rx_byte` and `digit` hold their values until the next accepted frame.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1 and the PARITY state exists.
  - Expected parity bit = XOR of the 8 data bits; a mismatch gives `parity_err`.
- Undefined:
  - Frame is 8N1 with no PARITY state.
  - `parity_err` is tied 0.

## Test plan
- Reset, line idle: `digit = 1`, `rx_byte = 0`, all pulses 0 for 20000 cycles.
- Send 8'h35 ('5') at 1250 clk/bit: one `rx_byte_valid` with `rx_byte = 8'h35`, one `digit_valid`, `digit = 5`, latency per Timing.
- Send 8'h41 ('A'), then 8'h39 back-to-back:
  - First frame: `rx_byte_valid` with 8'h41; `digit` stays at its prior value.
  - Second frame: `digit = 9` with `digit_valid`.
- Low glitch of 300 cycles on the idle line: no pulses, FSM back in IDLE. Next a valid '2' still gives `digit = 2`.
- Frame '7' with stop bit 0, line held low for 5 bit times, then idle:
  - One `frame_err` and no valid pulses.
  - No second start is detected until the line has returned high.
  - Assert `rst_n` = 0 during bit 4 of a following '3' frame: outputs return to reset values and no pulse follows.
- With `UART_RX_PARITY_EN`:
  - '4' with correct even parity → `digit = 4`.
  - '4' with parity bit inverted → `parity_err` pulse and `digit` unchanged.

Source files
------------

// File: rtl/uart_digit_rx.sv
// uart_digit_rx: 8N1 UART receiver with ASCII digit decode; define UART_RX_PARITY_EN for 8E1 with parity check
module uart_digit_rx #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx_pin,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP, BRK
  } state_t;
  state_t        r_state, w_next;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_rx_s, w_tick, w_perr, w_digit;
  assign w_rx_s  = r_sync[1];
  assign w_tick  = r_cnt == ((r_state == START) ? HALF_M1 : FULL_M1);
  assign w_digit = r_shift[7:4] == 4'h3 && r_shift[3:0] <= 4'd9;
  // two-flop synchroniser, idle-high reset so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], uart_rx_pin};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  // next-state: each bit is sampled at w_tick; BRK waits for the line to go high
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   w_next = w_rx_s ? IDLE : START;
      START:  w_next = !w_tick ? START : (w_rx_s ? IDLE : DATA);
`ifdef UART_RX_PARITY_EN
      DATA:   w_next = (w_tick && r_bit == 3'd7) ? PARITY : DATA;
      PARITY: w_next = w_tick ? STOP : PARITY;
`else
      DATA:   w_next = (w_tick && r_bit == 3'd7) ? STOP : DATA;
`endif
      STOP:   w_next = !w_tick ? STOP : (w_rx_s ? IDLE : BRK);
      BRK:    w_next = w_rx_s ? IDLE : BRK;
      default: w_next = IDLE;
    endcase
  end
  // baud counter held at zero in IDLE and wrapped at every sample point; LSB-first shift
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_cnt <= (r_state == IDLE || w_tick) ? '0 : r_cnt + 1'b1;
      if (r_state == START) r_bit <= '0;
      if (r_state == DATA && w_tick) begin
        r_shift <= {w_rx_s, r_shift[7:1]};
        r_bit   <= r_bit + 1'b1;
      end
    end
`ifdef UART_RX_PARITY_EN
  logic r_perr;
  assign w_perr = r_perr;
  // latch even-parity mismatch for use at the stop bit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                          r_perr <= 1'b0;
    else if (r_state == PARITY && w_tick) r_perr <= w_rx_s ^ (^r_shift);
`else
  assign w_perr = 1'b0;
`endif
  // registered results: only a frame with a good stop bit and parity updates the byte/digit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_byte       <= 8'h00;
      rx_byte_valid <= 1'b0;
      digit         <= 4'd1;
      digit_valid   <= 1'b0;
      frame_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err    <= 1'b0;
`endif
    end else begin
      rx_byte_valid <= 1'b0;
      digit_valid   <= 1'b0;
      frame_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err    <= 1'b0;
`endif
      if (r_state == STOP && w_tick) begin
        frame_err <= !w_rx_s;
`ifdef UART_RX_PARITY_EN
        parity_err <= w_rx_s && w_perr;
`endif
        if (w_rx_s && !w_perr) begin
          rx_byte       <= r_shift;
          rx_byte_valid <= 1'b1;
          if (w_digit) begin
            digit       <= r_shift[3:0];
            digit_valid <= 1'b1;
          end
        end
      end
    end
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_digit_rx.sv
// tb_uart_digit_rx: random and directed frames against a frame-level model of the receiver
module tb_uart_digit_rx;
  localparam int CLK_HZ = 410000;
  localparam int BAUD   = 10000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  localparam int LAT = 3 + HALF + NB * CPB;
  logic clk = 0, rst_n = 0, pin = 1;
  logic [7:0] rx_byte;
  logic [3:0] digit;
  logic rx_byte_valid, digit_valid, frame_err, parity_err;
  int cyc = 0, n_bv = 0, n_dv = 0, n_fe = 0, n_pe = 0, bv_cyc = 0;
  int n_vec = 0, n_bad = 0;
  logic [7:0] m_byte;
  logic [3:0] m_digit;
  uart_digit_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx_pin(pin),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .digit(digit), .digit_valid(digit_valid),
    .frame_err(frame_err), .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_byte_valid) begin
      n_bv   <= n_bv + 1;
      bv_cyc <= cyc;
    end
    if (digit_valid) n_dv <= n_dv + 1;
    if (frame_err)   n_fe <= n_fe + 1;
    if (parity_err)  n_pe <= n_pe + 1;
  end
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive_bit(logic b);
    pin = b;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic send(logic [7:0] b, logic stop, logic pflip, output int t0);
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ pflip);
`endif
    drive_bit(stop);
  endtask
  task automatic frame(string tag, logic [7:0] b, logic stop, logic pflip);
    int bv0 = n_bv, dv0 = n_dv, fe0 = n_fe, pe0 = n_pe, t0;
    logic pe, good, isdig;
`ifdef UART_RX_PARITY_EN
    pe = pflip;
`else
    pe = 1'b0;
`endif
    good  = stop && !pe;
    isdig = good && b >= 8'h30 && b <= 8'h39;
    send(b, stop, pflip, t0);
    check({tag, "_bv"}, n_bv - bv0, {31'd0, good});
    check({tag, "_dv"}, n_dv - dv0, {31'd0, isdig});
    check({tag, "_fe"}, n_fe - fe0, {31'd0, !stop});
    check({tag, "_pe"}, n_pe - pe0, {31'd0, stop && pe});
    if (good) begin
      m_byte = b;
      check({tag, "_lat"}, bv_cyc - t0, LAT);
    end
    if (isdig) m_digit = b[3:0];
    check({tag, "_byte"}, {24'd0, rx_byte}, {24'd0, m_byte});
    check({tag, "_digit"}, {28'd0, digit}, {28'd0, m_digit});
  endtask
  task automatic quiet(string tag, int n);
    int s0 = n_bv + n_dv + n_fe + n_pe;
    repeat (n) @(negedge clk);
    check({tag, "_pulses"}, n_bv + n_dv + n_fe + n_pe - s0, 0);
  endtask
  initial begin
    logic [7:0] b;
    logic stop, pflip;
    m_byte  = 8'h00;
    m_digit = 4'd1;
    repeat (3) @(negedge clk);
    check("rst_byte", {24'd0, rx_byte}, 0);
    check("rst_digit", {28'd0, digit}, 1);
    check("rst_pulses", {28'd0, rx_byte_valid, digit_valid, frame_err, parity_err}, 0);
    rst_n = 1;
    quiet("idle", 20000);
    check("idle_byte", {24'd0, rx_byte}, 0);
    check("idle_digit", {28'd0, digit}, 1);
    frame("d5", 8'h35, 1'b1, 1'b0);
    drive_bit(1'b1);
    frame("bA", 8'h41, 1'b1, 1'b0);
    frame("d9", 8'h39, 1'b1, 1'b0);
    drive_bit(1'b1);
    pin = 1'b0;
    repeat (10) @(negedge clk);
    pin = 1'b1;
    quiet("glitch", 3 * CPB);
    frame("d2", 8'h32, 1'b1, 1'b0);
    drive_bit(1'b1);
    frame("d7ferr", 8'h37, 1'b0, 1'b0);
    pin = 1'b0;
    quiet("break", 5 * CPB);
    pin = 1'b1;
    quiet("break_end", 2 * CPB);
    b = 8'h33;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    pin = b[4];
    repeat (HALF) @(negedge clk);
    rst_n = 0;
    #1;
    check("arst_byte", {24'd0, rx_byte}, 0);
    check("arst_digit", {28'd0, digit}, 1);
    pin = 1'b1;
    m_byte  = 8'h00;
    m_digit = 4'd1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    quiet("post_rst", 15 * CPB);
    check("post_rst_byte", {24'd0, rx_byte}, 0);
    check("post_rst_digit", {28'd0, digit}, 1);
    frame("d3", 8'h33, 1'b1, 1'b0);
    drive_bit(1'b1);
`ifdef UART_RX_PARITY_EN
    frame("p4", 8'h34, 1'b1, 1'b0);
    frame("p4bad", 8'h34, 1'b1, 1'b1);
    drive_bit(1'b1);
`endif
    for (int k = 0; k < 40; k++) begin
      b     = $urandom_range(1) ? 8'(8'h30 + $urandom_range(9)) : 8'($urandom_range(255));
      stop  = $urandom_range(99) < 85;
      pflip = $urandom_range(3) == 0;
      frame("rnd", b, stop, pflip);
      if (!stop || $urandom_range(1) == 1) drive_bit(1'b1);
    end
    drive_bit(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
